// File: rtl/uart_mmio.sv
// Memory-mapped UART at 0xC004-0xC007: transmitter, receiver with a 4-entry
// receive FIFO, sticky error flags and a programmable bit-period divisor.
module uart_mmio (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        tx,
    input  logic        rx
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DIV_W   = 16;
    localparam int unsigned BIT_W   = 3;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 3;
    localparam logic [DIV_W-1:0] BAUD_RST = 16'd434;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Register decode
    logic sel, wr_tx, rd_rx, wr_st, wr_baud;
    assign sel     = (addr[15:2] == 14'h3001);
    assign wr_tx   = we && sel && (addr[1:0] == 2'd0);
    assign rd_rx   = re && sel && (addr[1:0] == 2'd1);
    assign wr_st   = we && sel && (addr[1:0] == 2'd2);
    assign wr_baud = we && sel && (addr[1:0] == 2'd3);

    logic [DIV_W-1:0] baud;

    // ---------------- Transmitter ----------------
    state_t            tx_state, tx_state_d;
    logic [DIV_W-1:0]  tx_cnt, tx_cnt_d, tx_div, tx_div_d;
    logic [BIT_W-1:0]  tx_bit, tx_bit_d;
    logic [DATA_W-1:0] tx_shift, tx_shift_d;
    logic              tx_d, tx_busy;

    assign tx_busy = (tx_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_div   <= tx_div_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx       <= tx_d;
        end
    end

    // Divisor is captured at frame start so BAUD writes only affect later frames
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_div_d   = tx_div;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_d       = tx;
        case (tx_state)
            IDLE: begin
                tx_d = 1'b1;
                if (wr_tx) begin
                    tx_state_d = START;
                    tx_cnt_d   = '0;
                    tx_div_d   = baud;
                    tx_bit_d   = '0;
                    tx_shift_d = wdata[7:0];
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (tx_cnt == tx_div) begin
                    tx_state_d = DATA;
                    tx_cnt_d   = '0;
                    tx_d       = tx_shift[0];
                end else begin
                    tx_cnt_d = tx_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                if (tx_cnt == tx_div) begin
                    tx_cnt_d = '0;
                    if (tx_bit == BIT_W'(7)) begin
                        tx_state_d = STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit + BIT_W'(1);
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        tx_d       = tx_shift[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                if (tx_cnt == tx_div) begin
                    tx_state_d = IDLE;
                    tx_d       = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt + DIV_W'(1);
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // ---------------- Receiver ----------------
    logic [1:0]        rx_sync;
    logic              rxs, rx_prev;
    state_t            rx_state, rx_state_d;
    logic [DIV_W-1:0]  rx_cnt, rx_cnt_d, rx_div, rx_div_d, rx_half;
    logic [BIT_W-1:0]  rx_bit, rx_bit_d;
    logic [DATA_W-1:0] rx_shift, rx_shift_d;
    logic              rx_push_c, rx_ferr_c;

    assign rxs     = rx_sync[1];
    assign rx_half = DIV_W'((17'(rx_div) + 17'd1) >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_prev  <= rxs;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_div   <= rx_div_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
        end
    end

    // Edge-detect cycle counts as the first START clock
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_div_d   = rx_div;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_push_c  = 1'b0;
        rx_ferr_c  = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rxs) begin
                    rx_state_d = START;
                    rx_cnt_d   = DIV_W'(1);
                    rx_div_d   = baud;
                end
            end
            START: begin
                if (rx_cnt >= rx_half) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rxs ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                if (rx_cnt == rx_div) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxs, rx_shift[7:1]};
                    if (rx_bit == BIT_W'(7)) rx_state_d = STOP;
                    else                     rx_bit_d   = rx_bit + BIT_W'(1);
                end else begin
                    rx_cnt_d = rx_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                if (rx_cnt == rx_div) begin
                    rx_state_d = IDLE;
                    rx_push_c  = rxs;
                    rx_ferr_c  = !rxs;
                end else begin
                    rx_cnt_d = rx_cnt + DIV_W'(1);
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // ---------------- RX FIFO, flags, divisor ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              frm_err, rx_ovf, rx_full, rx_avail, pop, push_ok, drop;

    assign rx_full  = (count == CNT_W'(DEPTH));
    assign rx_avail = (count != '0);
    assign pop      = rd_rx && rx_avail;
    assign push_ok  = rx_push_c && (!rx_full || pop);
    assign drop     = rx_push_c && rx_full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= rx_shift;
    end

    // Status clear is applied before new events so a same-cycle event is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            frm_err <= 1'b0;
            rx_ovf  <= 1'b0;
            baud    <= BAUD_RST;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
            if (wr_st) begin
                frm_err <= 1'b0;
                rx_ovf  <= 1'b0;
            end
            if (drop)      rx_ovf  <= 1'b1;
            if (rx_ferr_c) frm_err <= 1'b1;
            if (wr_baud)   baud    <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (re && sel) begin
            case (addr[1:0])
                2'd1:    if (rx_avail) rdata = {8'h00, mem[rd_ptr]};
                2'd2:    rdata = {11'b0, frm_err, rx_ovf, rx_full, rx_avail, tx_busy};
                2'd3:    rdata = baud;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio: TX framing, RX path, FIFO
// boundaries, error flags and reset behaviour at a divisor of 3.
module tb_uart_mmio;

    localparam logic [15:0] A_TXD  = 16'hC004;
    localparam logic [15:0] A_RXD  = 16'hC005;
    localparam logic [15:0] A_STAT = 16'hC006;
    localparam logic [15:0] A_BAUD = 16'hC007;

    logic        clk = 1'b0;
    logic        rst, we, re, tx, rx;
    logic [15:0] addr, wdata, rdata;

    int checks   = 0;
    int failures = 0;

    uart_mmio dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re),
        .wdata(wdata), .rdata(rdata), .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        addr = a; wdata = d; we = 1'b1;
        cyc(1);
        we = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        addr = a; re = 1'b1;
        #1 d = rdata;
        cyc(1);
        re = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        cyc(4);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            cyc(4);
        end
        rx = stop;
        cyc(4);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; rx = 1'b1;
        cyc(3);
        rst = 1'b0;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_status: got %h expected 0000", d); end
        bus_rd(A_BAUD, d);
        checks++; if (d !== 16'h01B2) begin failures++; $display("FAIL reset_baud: got %h expected 01b2", d); end
        bus_rd(A_RXD, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_rxdata: got %h expected 0000", d); end
    endtask

    task automatic test_tx_frame();
        logic [15:0] d;
        logic [9:0]  fr;
        int          lows;
        fr = {1'b1, 8'hA5, 1'b0};
        bus_wr(A_BAUD, 16'd3);
        bus_wr(A_TXD, 16'h00A5);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (tx !== fr[i/4]) begin failures++; $display("FAIL tx_bit cycle %0d: got %b expected %b", i, tx, fr[i/4]); end
            if (i == 6) begin addr = A_TXD; wdata = 16'h005A; we = 1'b1; end
            if (i == 12) begin
                addr = A_STAT; re = 1'b1; #1;
                checks++; if (rdata !== 16'h0001) begin failures++; $display("FAIL busy_status: got %h expected 0001", rdata); end
            end
            if (i == 16) begin
                addr = A_TXD; re = 1'b1; #1;
                checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL txdata_read: got %h expected 0000", rdata); end
            end
            if (i == 18) begin
                addr = A_STAT; re = 1'b0; #1;
                checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL rdata_no_re: got %h expected 0000", rdata); end
            end
            if (i == 20) begin
                addr = 16'hC008; re = 1'b1; #1;
                checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL unmapped_read: got %h expected 0000", rdata); end
            end
            if (i == 24) begin addr = 16'hC003; wdata = 16'h0009; we = 1'b1; end
            cyc(1);
            we = 1'b0; re = 1'b0;
        end
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL idle_status: got %h expected 0000", d); end
        bus_rd(A_BAUD, d);
        checks++; if (d !== 16'h0003) begin failures++; $display("FAIL unmapped_write: got %h expected 0003", d); end
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            if (tx !== 1'b1) lows++;
            cyc(1);
        end
        checks++; if (lows !== 0) begin failures++; $display("FAIL dropped_write: got %0d low cycles expected 0", lows); end
    endtask

    task automatic test_back_to_back();
        bus_wr(A_TXD, 16'h000F);
        cyc(39);
        bus_wr(A_TXD, 16'h0000);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL b2b_idle: got %b expected 1", tx); end
        bus_wr(A_TXD, 16'h00FF);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL b2b_start: got %b expected 0", tx); end
        cyc(4);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL b2b_data: got %b expected 1", tx); end
        cyc(36);
    endtask

    task automatic test_rx_basic();
        logic [15:0] d;
        send_byte(8'h3C, 1'b1);
        cyc(4);
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0002) begin failures++; $display("FAIL rx_avail: got %h expected 0002", d); end
        bus_rd(A_RXD, d);
        checks++; if (d !== 16'h003C) begin failures++; $display("FAIL rx_data: got %h expected 003c", d); end
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rx_drained: got %h expected 0000", d); end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        logic [7:0]  bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int k = 0; k < 5; k++) send_byte(bytes[k], 1'b1);
        cyc(4);
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h000E) begin failures++; $display("FAIL ovf_status: got %h expected 000e", d); end
        for (int k = 0; k < 4; k++) begin
            bus_rd(A_RXD, d);
            checks++; if (d !== {8'h00, bytes[k]}) begin failures++; $display("FAIL ovf_read %0d: got %h expected %h", k, d, {8'h00, bytes[k]}); end
        end
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0008) begin failures++; $display("FAIL ovf_sticky: got %h expected 0008", d); end
        bus_wr(A_STAT, 16'h0000);
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL ovf_clear: got %h expected 0000", d); end
        bus_rd(A_RXD, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL empty_read: got %h expected 0000", d); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] d;
        send_byte(8'h81, 1'b1);
        bus_rd(A_RXD, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL empty_poppush_read: got %h expected 0000", d); end
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0002) begin failures++; $display("FAIL empty_poppush_status: got %h expected 0002", d); end
        bus_rd(A_RXD, d);
        checks++; if (d !== 16'h0081) begin failures++; $display("FAIL empty_poppush_data: got %h expected 0081", d); end
        for (int k = 1; k <= 4; k++) send_byte(8'hA0 + 8'(k), 1'b1);
        cyc(4);
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0006) begin failures++; $display("FAIL full_status: got %h expected 0006", d); end
        send_byte(8'hA5, 1'b1);
        bus_rd(A_RXD, d);
        checks++; if (d !== 16'h00A1) begin failures++; $display("FAIL full_poppush_read: got %h expected 00a1", d); end
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0006) begin failures++; $display("FAIL full_poppush_status: got %h expected 0006", d); end
        for (int k = 2; k <= 5; k++) begin
            bus_rd(A_RXD, d);
            checks++; if (d !== {8'h00, 8'hA0 + 8'(k)}) begin failures++; $display("FAIL full_drain %0d: got %h expected %h", k, d, {8'h00, 8'hA0 + 8'(k)}); end
        end
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL full_drained: got %h expected 0000", d); end
    endtask

    task automatic test_frame_err();
        logic [15:0] d;
        rx = 1'b0;
        cyc(1);
        rx = 1'b1;
        cyc(10);
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL glitch_status: got %h expected 0000", d); end
        send_byte(8'h99, 1'b0);
        cyc(6);
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0010) begin failures++; $display("FAIL frm_err_status: got %h expected 0010", d); end
        bus_rd(A_RXD, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL frm_err_nopush: got %h expected 0000", d); end
        bus_wr(A_STAT, 16'hFFFF);
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL frm_err_clear: got %h expected 0000", d); end
    endtask

    task automatic test_reset_mid_tx();
        logic [15:0] d;
        int          lows;
        bus_wr(A_TXD, 16'h0000);
        cyc(21);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL midframe_tx: got %b expected 0", tx); end
        rst = 1'b1;
        cyc(1);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL abort_tx: got %b expected 1", tx); end
        rst = 1'b0;
        bus_rd(A_STAT, d);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL abort_status: got %h expected 0000", d); end
        bus_rd(A_BAUD, d);
        checks++; if (d !== 16'h01B2) begin failures++; $display("FAIL abort_baud: got %h expected 01b2", d); end
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1) lows++;
            cyc(1);
        end
        checks++; if (lows !== 0) begin failures++; $display("FAIL abort_idle: got %0d low cycles expected 0", lows); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_rx_basic();
        test_overflow();
        test_simultaneous();
        test_frame_err();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
